// File: rtl/acc_datapath_gen.sv
// Accumulator datapath: ACC plus Z/N/C flags, executing one command per handshake against a data RAM.
// Optional macro ACC_SAT_EN selects unsigned saturating ADD/SUB instead of wrap-around.
module acc_datapath_gen #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned SIGN_EXT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_operand,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] acc_out,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              busy
);

    localparam int unsigned CNT_W = 3;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LD   = 3'b001;
    localparam logic [2:0] OP_LDI  = 3'b010;
    localparam logic [2:0] OP_ST   = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SUBI = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        EXEC    = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   lat_cnt;

    logic [DATA_W-1:0]  ext_operand;
    logic [2:0]         cur_op;
    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W:0]    sum_ext;
    logic [DATA_W:0]    diff_ext;
    logic               is_arith;
    logic               is_sub;
    logic               alu_c;
    logic [DATA_W-1:0]  alu_raw;
    logic [DATA_W-1:0]  alu_res;
    logic [DATA_W-1:0]  upd_val;

    // Shared ALU: immediate path in IDLE, memory path in EXEC using the latched opcode
    always_comb begin
        if (SIGN_EXT != 0) begin
            ext_operand = DATA_W'($signed(cmd_operand));
        end else begin
            ext_operand = DATA_W'(cmd_operand);
        end

        cur_op   = (state == EXEC) ? op_q : cmd_op;
        alu_b    = (state == EXEC) ? mem_rdata : ext_operand;
        is_arith = cur_op[2];
        is_sub   = cur_op[1];

        sum_ext  = {1'b0, acc_out} + {1'b0, alu_b};
        diff_ext = {1'b0, acc_out} - {1'b0, alu_b};

        alu_c    = is_sub ? diff_ext[DATA_W] : sum_ext[DATA_W];
        alu_raw  = is_sub ? diff_ext[DATA_W-1:0] : sum_ext[DATA_W-1:0];

`ifdef ACC_SAT_EN
        // Clamp on carry/borrow; the flag still reports the raw condition
        if (alu_c) begin
            alu_res = is_sub ? '0 : '1;
        end else begin
            alu_res = alu_raw;
        end
`else
        alu_res = alu_raw;
`endif

        upd_val = is_arith ? alu_res : alu_b;
    end

    // Control FSM, strobes and architectural state; everything updates on the falling edge
    always_ff @(negedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_NOP;
            lat_cnt   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            acc_out   <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LD, OP_ADD, OP_SUB: begin
                                mem_addr  <= cmd_operand;
                                mem_rd_en <= 1'b1;
                                op_q      <= cmd_op;
                                lat_cnt   <= CNT_W'(MEM_LAT);
                                state     <= RD_WAIT;
                                cmd_ready <= 1'b0;
                                busy      <= 1'b1;
                            end
                            OP_LDI, OP_ADDI, OP_SUBI: begin
                                acc_out <= upd_val;
                                flag_z  <= (upd_val == '0);
                                flag_n  <= upd_val[DATA_W-1];
                                if (is_arith) begin
                                    flag_c <= alu_c;
                                end
                            end
                            OP_ST: begin
                                mem_addr  <= cmd_operand;
                                mem_wdata <= acc_out;
                                mem_wr_en <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                RD_WAIT: begin
                    lat_cnt <= lat_cnt - CNT_W'(1);
                    if (lat_cnt == CNT_W'(1)) begin
                        state <= EXEC;
                    end
                end

                EXEC: begin
                    acc_out <= upd_val;
                    flag_z  <= (upd_val == '0);
                    flag_n  <= upd_val[DATA_W-1];
                    if (is_arith) begin
                        flag_c <= alu_c;
                    end
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_datapath_gen.sv
// Directed bench for acc_datapath_gen: reference model feeds a scoreboard queue, RAM model with 2-edge latency.
module tb_acc_datapath_gen;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned MEM_LAT  = 2;
    localparam int unsigned SIGN_EXT = 0;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LD   = 3'b001;
    localparam logic [2:0] LDI  = 3'b010;
    localparam logic [2:0] ST   = 3'b011;
    localparam logic [2:0] ADD  = 3'b100;
    localparam logic [2:0] ADDI = 3'b101;
    localparam logic [2:0] SUB  = 3'b110;
    localparam logic [2:0] SUBI = 3'b111;

    typedef struct packed {
        logic [15:0] acc;
        logic        z;
        logic        n;
        logic        c;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_operand;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] acc_out;
    logic              flag_z;
    logic              flag_n;
    logic              flag_c;
    logic              busy;

    acc_datapath_gen #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT),
        .SIGN_EXT(SIGN_EXT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_operand(cmd_operand),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .acc_out    (acc_out),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_c     (flag_c),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read strobe seen at edge E, data sampleable at edge E+2
    logic [15:0] mem [0:2047];
    logic        bd_we;
    logic [10:0] bd_addr;
    logic [15:0] bd_data;
    logic        pv0;
    logic [15:0] pipe0;

    always @(negedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        pv0       <= mem_rd_en;
        pipe0     <= mem[mem_addr];
        mem_rdata <= pv0 ? pipe0 : 16'hxxxx;
    end

    int unsigned checks;
    int unsigned failures;
    exp_t        sb[$];
    logic [15:0] ref_mem [0:2047];
    logic [15:0] m_acc;
    logic        m_z, m_n, m_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ext(input logic [10:0] v);
        if (SIGN_EXT != 0) return {{5{v[10]}}, v};
        return {5'b0, v};
    endfunction

    // Reference model: computes the architectural result and queues it
    task automatic predict(input logic [2:0] op, input logic [10:0] opnd);
        logic [15:0] b;
        int          full;
        b = (op == LD || op == ADD || op == SUB) ? ref_mem[opnd] : ext(opnd);
        case (op)
            LD, LDI: m_acc = b;
            ADD, ADDI: begin
                full = int'(m_acc) + int'(b);
                m_c  = (full > 65535);
`ifdef ACC_SAT_EN
                m_acc = m_c ? 16'hFFFF : full[15:0];
`else
                m_acc = full[15:0];
`endif
            end
            SUB, SUBI: begin
                m_c = (m_acc < b);
`ifdef ACC_SAT_EN
                m_acc = m_c ? 16'h0000 : m_acc - b;
`else
                m_acc = m_acc - b;
`endif
            end
            ST: ref_mem[opnd] = m_acc;
            default: ;
        endcase
        if (op != ST && op != NOP) begin
            m_z = (m_acc == 16'h0000);
            m_n = m_acc[15];
        end
        sb.push_back('{acc: m_acc, z: m_z, n: m_n, c: m_c});
    endtask

    task automatic backdoor(input logic [10:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        bd_we = 1'b0;
    endtask

    // Issue one command at the current posedge, wait for completion, compare against the scoreboard
    task automatic run(input logic [2:0] op, input logic [10:0] opnd);
        exp_t e;
        int   busy_edges;
        logic is_rd;
        is_rd = (op == LD || op == ADD || op == SUB);
        check("ready_before_cmd", cmd_ready, 1);
        predict(op, opnd);
        cmd_valid = 1'b1; cmd_op = op; cmd_operand = opnd;
        @(negedge clk);
        @(posedge clk);
        cmd_valid = 1'b0;
        if (op == ST) begin
            check("st_wr_en", mem_wr_en, 1);
            check("st_addr", mem_addr, opnd);
            check("st_wdata", mem_wdata, m_acc);
        end
        if (is_rd) begin
            check("rd_en", mem_rd_en, 1);
            check("rd_addr", mem_addr, opnd);
            busy_edges = 0;
            while (!cmd_ready && busy_edges < 20) begin
                busy_edges++;
                @(posedge clk);
                if (busy_edges == 1) check("rd_en_one_edge", mem_rd_en, 0);
            end
            check("busy_edges", busy_edges, MEM_LAT + 1);
        end
        e = sb.pop_front();
        check("acc", acc_out, e.acc);
        check("flag_z", flag_z, e.z);
        check("flag_n", flag_n, e.n);
        check("flag_c", flag_c, e.c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        m_acc = 16'h0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_operand = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        @(posedge clk);
        backdoor(11'h010, 16'h1234);
        backdoor(11'h011, 16'hFFFF);
        backdoor(11'h012, 16'h0234);
        backdoor(11'h030, 16'h0001);

        check("rst_acc", acc_out, 0);
        check("rst_z", flag_z, 0);
        check("rst_n", flag_n, 0);
        check("rst_c", flag_c, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        reset = 1'b0;

        run(LDI, 11'h7FF);
        run(LDI, 11'h055);
        run(ST, 11'h020);
        @(posedge clk);
        check("st_wr_en_one_edge", mem_wr_en, 0);

        run(LD, 11'h010);
        run(LD, 11'h011);
        run(ADDI, 11'h001);
        run(LDI, 11'h003);
        run(SUBI, 11'h005);
        run(LDI, 11'h100);
        run(ADD, 11'h012);
        run(SUB, 11'h010);
        run(LD, 11'h020);
        run(ST, 11'h021);
        run(NOP, 11'h000);
        check("nop_ready", cmd_ready, 1);

        // Reset while a read op is in flight, with a new command offered on the reset edge
        run(LDI, 11'h010);
        cmd_valid = 1'b1; cmd_op = ADD; cmd_operand = 11'h030;
        @(negedge clk);
        @(posedge clk);
        check("mid_rd_en", mem_rd_en, 1);
        check("mid_busy", busy, 1);
        reset = 1'b1; cmd_op = LDI; cmd_operand = 11'h123;
        @(negedge clk);
        @(posedge clk);
        cmd_valid = 1'b0; reset = 1'b0;
        m_acc = 16'h0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
        check("abort_acc", acc_out, 0);
        check("abort_z", flag_z, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_rd_en", mem_rd_en, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_wdata", mem_wdata, 0);
        repeat (4) @(posedge clk);
        check("late_rdata_acc", acc_out, 0);
        check("late_rdata_ready", cmd_ready, 1);

        run(LDI, 11'h7FF);
        run(ADD, 11'h030);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
